// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard control bundle: decode instruction fields and pipeline
// status in, pipeline register enables / flush / bubble / halt status out.
// Latency: none (wiring only). Backpressure: carried by the enable outputs.
//
// Ports (by modport):
//   master - the pipeline side: drives the decode instruction fields,
//            branch_taken and mem_stall; observes the control outputs.
//   slave  - the hazard controller: consumes the decode fields and status,
//            drives pc_en, ifid_en, ifid_flush, idex_en, idex_bubble_n,
//            halt_done.
interface id_hazard_ctrl_if;
  // Decode-stage instruction description
  logic       id_valid;
  logic [2:0] rd1_sel;
  logic [2:0] rd2_sel;
  logic       rd1_used;
  logic       rd2_used;
  logic [2:0] wr_sel;
  logic       RegWrite;
  logic       MemtoReg;
  logic       Halt;

  // Pipeline status from later stages
  logic       branch_taken;
  logic       mem_stall;

  // Pipeline control outputs
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_bubble_n;
  logic       halt_done;

  modport master (
    output id_valid, rd1_sel, rd2_sel, rd1_used, rd2_used,
           wr_sel, RegWrite, MemtoReg, Halt, branch_taken, mem_stall,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble_n, halt_done
  );

  modport slave (
    input  id_valid, rd1_sel, rd2_sel, rd1_used, rd2_used,
           wr_sel, RegWrite, MemtoReg, Halt, branch_taken, mem_stall,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble_n, halt_done
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage pipeline control: RAW/load-use stalls, branch flush, memory freeze, halt drain.
// Latency: all control outputs are combinational from inputs + state; state moves on rising clk.
// Backpressure: mem_stall freezes everything; hazards/drain hold PC and IF/ID and inject ID/EX bubbles.
//
// Ports:
//   clk   - sole clock, rising edge.
//   rst_n - asynchronous active-low reset.
//   ctl   - id_hazard_ctrl_if slave: decode instruction fields, branch_taken,
//           mem_stall in; pc_en, ifid_en, ifid_flush, idex_en, idex_bubble_n,
//           halt_done out.
// Parameter FORWARD: 1 = EX/MEM->EX forwarding exists, only load-use stalls;
//                    0 = stall on any RAW against the EX or MEM writer.
module id_hazard_ctrl #(
  parameter bit FORWARD = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  id_hazard_ctrl_if.slave ctl
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // In-flight writer in EX; the load flag is only needed there because a
  // load's data becomes forwardable once it has left MEM's input.
  typedef struct packed {
    logic       v;
    logic [2:0] dest;
    logic       ld;
  } ex_slot_t;

  typedef struct packed {
    logic       v;
    logic [2:0] dest;
  } mem_slot_t;

  // HALT needs three more non-frozen edges to move from ID into WB.
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  state_t    state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q, mem_d;

  logic frozen;
  logic running;
  logic match_ex;
  logic match_mem;
  logic raw_hit;
  logic hazard;
  logic accept;

  // A source only counts when the instruction actually reads it; r0 is an
  // ordinary register here, so no special case for index 0.
  function automatic logic src_match(
    input logic       v,
    input logic [2:0] dest,
    input logic [2:0] r1,
    input logic       u1,
    input logic [2:0] r2,
    input logic       u2
  );
    return v & ((u1 & (r1 == dest)) | (u2 & (r2 == dest)));
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    frozen    = ctl.mem_stall;
    running   = (state_q == ST_RUN);
    match_ex  = src_match(ex_q.v, ex_q.dest, ctl.rd1_sel, ctl.rd1_used,
                          ctl.rd2_sel, ctl.rd2_used);
    match_mem = src_match(mem_q.v, mem_q.dest, ctl.rd1_sel, ctl.rd1_used,
                          ctl.rd2_sel, ctl.rd2_used);
    // With forwarding only a load still in EX lacks its data in time. The
    // write-back stage bypasses into the register file read, so no WB check.
    if (FORWARD) begin
      raw_hit = match_ex & ex_q.ld;
    end else begin
      raw_hit = match_ex | match_mem;
    end
    hazard = ctl.id_valid & raw_hit;
    accept = ctl.id_valid & ~frozen & ~ctl.branch_taken & running & ~hazard;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: mirrors the RegWrite/dest/load of what sits in EX and MEM.
  // Anything not accepted (stall, flush, drain, idle) enters EX as a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!frozen) begin
      mem_d.v    = ex_q.v;
      mem_d.dest = ex_q.dest;
      ex_d.v     = ctl.RegWrite & accept;
      ex_d.dest  = ctl.wr_sel;
      ex_d.ld    = ctl.MemtoReg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Halt FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Halt FSM: next state. A frozen cycle does not move the HALT down the pipe,
  // so it must not advance the drain count either.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!frozen) begin
      unique case (state_q)
        ST_RUN: begin
          // accept already excludes wrong-path HALTs squashed by a branch.
          if (accept && ctl.Halt) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_CYCLES;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 2'd0) begin
            state_d = ST_HALTED;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Halt FSM + hazard: outputs, in priority order
  //   mem_stall    : freeze every register, no bubble (ID/EX simply holds)
  //   branch_taken : fetch the target, flush IF/ID, squash decode into EX
  //   drain/halted : stop fetching, keep pushing bubbles so the pipe empties
  //   hazard       : hold PC and IF/ID, bubble into EX
  // ---------------------------------------------------------------------------
  always_comb begin
    ctl.pc_en         = 1'b1;
    ctl.ifid_en       = 1'b1;
    ctl.ifid_flush    = 1'b0;
    ctl.idex_en       = 1'b1;
    ctl.idex_bubble_n = 1'b1;
    if (frozen) begin
      ctl.pc_en   = 1'b0;
      ctl.ifid_en = 1'b0;
      ctl.idex_en = 1'b0;
    end else if (ctl.branch_taken) begin
      ctl.ifid_flush    = 1'b1;
      ctl.idex_bubble_n = 1'b0;
    end else if (!running || hazard) begin
      ctl.pc_en         = 1'b0;
      ctl.ifid_en       = 1'b0;
      ctl.idex_bubble_n = 1'b0;
    end
  end

  assign ctl.halt_done = (state_q == ST_HALTED);

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: one instance with forwarding, one without,
// both fed the same decode stream; per-step expectations go through a queue.
module tb_id_hazard_ctrl;

  logic clk;
  logic rst_n;

  // Shared stimulus
  logic       id_valid;
  logic [2:0] rd1_sel, rd2_sel, wr_sel;
  logic       rd1_used, rd2_used;
  logic       reg_write, mem_to_reg, halt;
  logic       branch_taken, mem_stall;

  id_hazard_ctrl_if if_f1 ();
  id_hazard_ctrl_if if_f0 ();

  assign if_f1.id_valid     = id_valid;
  assign if_f1.rd1_sel      = rd1_sel;
  assign if_f1.rd2_sel      = rd2_sel;
  assign if_f1.rd1_used     = rd1_used;
  assign if_f1.rd2_used     = rd2_used;
  assign if_f1.wr_sel       = wr_sel;
  assign if_f1.RegWrite     = reg_write;
  assign if_f1.MemtoReg     = mem_to_reg;
  assign if_f1.Halt         = halt;
  assign if_f1.branch_taken = branch_taken;
  assign if_f1.mem_stall    = mem_stall;

  assign if_f0.id_valid     = id_valid;
  assign if_f0.rd1_sel      = rd1_sel;
  assign if_f0.rd2_sel      = rd2_sel;
  assign if_f0.rd1_used     = rd1_used;
  assign if_f0.rd2_used     = rd2_used;
  assign if_f0.wr_sel       = wr_sel;
  assign if_f0.RegWrite     = reg_write;
  assign if_f0.MemtoReg     = mem_to_reg;
  assign if_f0.Halt         = halt;
  assign if_f0.branch_taken = branch_taken;
  assign if_f0.mem_stall    = mem_stall;

  id_hazard_ctrl #(.FORWARD(1'b1)) dut_f1 (.clk(clk), .rst_n(rst_n), .ctl(if_f1));
  id_hazard_ctrl #(.FORWARD(1'b0)) dut_f0 (.clk(clk), .rst_n(rst_n), .ctl(if_f0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble_n, halt_done}
  localparam logic [5:0] ADV = 6'b110110;  // normal advance
  localparam logic [5:0] STL = 6'b000100;  // hazard stall / drain: bubble into EX
  localparam logic [5:0] FRZ = 6'b000010;  // memory freeze
  localparam logic [5:0] BRF = 6'b111100;  // taken branch flush
  localparam logic [5:0] HLT = 6'b000101;  // halted
  localparam logic [5:0] HFZ = 6'b000011;  // halted and frozen

  typedef struct {
    string      tag;
    bit         fwd;
    logic [5:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [5:0] observe(input bit fwd);
    if (fwd)
      return {if_f1.pc_en, if_f1.ifid_en, if_f1.ifid_flush,
              if_f1.idex_en, if_f1.idex_bubble_n, if_f1.halt_done};
    return {if_f0.pc_en, if_f0.ifid_en, if_f0.ifid_flush,
            if_f0.idex_en, if_f0.idex_bubble_n, if_f0.halt_done};
  endfunction

  task automatic ins(input logic v, input logic [2:0] r1, input logic u1,
                     input logic [2:0] r2, input logic u2, input logic [2:0] wd,
                     input logic rw, input logic ld, input logic h);
    id_valid = v;  rd1_sel = r1; rd1_used = u1; rd2_sel = r2; rd2_used = u2;
    wr_sel = wd;   reg_write = rw; mem_to_reg = ld; halt = h;
    branch_taken = 1'b0;
    mem_stall    = 1'b0;
  endtask

  task automatic idle();
    ins(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are already driven (just after a rising edge); queue expectations,
  // compare on the falling edge, then move to just past the next rising edge.
  task automatic step(input string tag, input logic [5:0] e_f1, input logic [5:0] e_f0);
    exp_t       e;
    logic [5:0] o;
    q.push_back('{tag, 1'b1, e_f1});
    q.push_back('{tag, 1'b0, e_f0});
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      o = observe(e.fwd);
      n_checks++;
      assert (o === e.exp) n_pass++;
      else $error("FAIL %s fwd=%0d observed=%b expected=%b", e.tag, e.fwd, o, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset values
    step("reset", ADV, ADV);
    rst_n = 1'b1;

    // Load-use: LD r2 ; ADD r3,r2,r1
    ins(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0); step("lu_ld",   ADV, ADV);
    ins(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0); step("lu_add0", STL, STL);
    step("lu_add1", ADV, STL);
    idle(); step("lu_idle0", ADV, ADV);
    step("lu_idle1", ADV, ADV);

    // RAW back-to-back: ADDI r4 ; SUB r5,r4,r4
    ins(1, 3'd1, 1, 3'd0, 0, 3'd4, 1, 0, 0); step("raw_addi", ADV, ADV);
    ins(1, 3'd4, 1, 3'd4, 1, 3'd5, 1, 0, 0); step("raw_sub0", ADV, STL);
    step("raw_sub1", ADV, STL);
    step("raw_sub2", ADV, ADV);
    idle(); step("raw_idle0", ADV, ADV);
    step("raw_idle1", ADV, ADV);

    // RAW with one NOP between
    ins(1, 3'd1, 1, 3'd0, 0, 3'd4, 1, 0, 0); step("gap_addi", ADV, ADV);
    idle();                                   step("gap_nop",  ADV, ADV);
    ins(1, 3'd4, 1, 3'd4, 1, 3'd5, 1, 0, 0); step("gap_sub0", ADV, STL);
    step("gap_sub1", ADV, ADV);
    idle(); step("gap_idle0", ADV, ADV);
    step("gap_idle1", ADV, ADV);

    // Sources not used: no stall
    ins(1, 3'd1, 1, 3'd0, 0, 3'd4, 1, 0, 0); step("unu_addi", ADV, ADV);
    ins(1, 3'd4, 0, 3'd4, 0, 3'd5, 1, 0, 0); step("unu_sub",  ADV, ADV);
    idle(); step("unu_idle0", ADV, ADV);
    step("unu_idle1", ADV, ADV);

    // r0 is an ordinary register
    ins(1, 3'd1, 1, 3'd0, 0, 3'd0, 1, 0, 0); step("r0_wr", ADV, ADV);
    ins(1, 3'd0, 1, 3'd1, 0, 3'd6, 1, 0, 0); step("r0_rd", ADV, STL);
    idle(); step("r0_idle0", ADV, ADV);
    step("r0_idle1", ADV, ADV);

    // mem_stall for 4 cycles during a load-use stall
    ins(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0); step("ms_ld", ADV, ADV);
    for (int i = 0; i < 4; i++) begin
      ins(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0);
      mem_stall = 1'b1;
      step($sformatf("ms_frz%0d", i), FRZ, FRZ);
    end
    ins(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0); step("ms_rel0", STL, STL);
    step("ms_rel1", ADV, STL);
    idle(); step("ms_idle0", ADV, ADV);
    step("ms_idle1", ADV, ADV);

    // Taken branch with HALT in decode: squashed, stays running
    ins(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); branch_taken = 1'b1; step("br_halt", BRF, BRF);
    idle(); step("br_after", ADV, ADV);
    ins(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); branch_taken = 1'b1; mem_stall = 1'b1;
    step("br_frz", FRZ, FRZ);
    ins(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); branch_taken = 1'b1; step("br_halt2", BRF, BRF);
    idle(); step("br_after2", ADV, ADV);
    // Branch beats a load-use hazard
    ins(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0); step("br_ld", ADV, ADV);
    ins(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0); branch_taken = 1'b1; step("br_haz", BRF, BRF);
    idle(); step("br_idle0", ADV, ADV);
    step("br_idle1", ADV, ADV);

    // HALT accepted: three drain cycles, then halted
    ins(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); step("halt_acc", ADV, ADV);
    idle(); step("drain0", STL, STL);
    step("drain1", STL, STL);
    step("drain2", STL, STL);
    step("halted", HLT, HLT);
    mem_stall = 1'b1; step("halted_frz", HFZ, HFZ);
    ins(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0); step("halted_ins", HLT, HLT);

    idle(); rst_n = 1'b0; step("reset2", ADV, ADV);
    rst_n = 1'b1;

    // HALT with one mem_stall cycle right after acceptance
    ins(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); step("halt_acc2", ADV, ADV);
    idle(); mem_stall = 1'b1; step("drain_frz", FRZ, FRZ);
    idle(); step("drain_s0", STL, STL);
    step("drain_s1", STL, STL);
    step("drain_s2", STL, STL);
    step("halted2", HLT, HLT);

    idle(); rst_n = 1'b0; step("reset3", ADV, ADV);
    rst_n = 1'b1;

    // Reset in the middle of a drain with a load still tracked in MEM
    ins(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0); step("rd_ld",   ADV, ADV);
    ins(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1); step("rd_halt", ADV, ADV);
    ins(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0); rst_n = 1'b0;
    step("rst_drain", ADV, ADV);
    rst_n = 1'b1;
    step("post_rst", ADV, ADV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline control block for the decode stage of the 5-stage processor. It tracks in-flight register writers in EX and MEM with an internal 2-entry scoreboard and detects RAW and load-use hazards against the instruction in decode. It also applies taken-branch flushes, freezes on data-memory stalls and drains the pipe on Halt. It drives PC, IF/ID and ID/EX enables, plus the ID/EX bubble-inject input, which gates RegWrite/DMemEn/DMemWrite into EX.

## Interface
- FORWARD, 1, 1: EX/MEM→EX forwarding exists, only load-use stalls; 0: stall on any RAW against EX or MEM.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction.
- rd1_sel / rd2_sel  in  3 each  source register indices of decode instruction.
- rd1_used / rd2_used  in  1 each  source actually read.
- wr_sel  in  3  destination index of decode instruction.
- RegWrite  in  1  decode instruction writes the register file.
- MemtoReg  in  1  decode instruction is a load.
- Halt  in  1  decode instruction is HALT.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- mem_stall  in  1  data memory busy; whole pipe must freeze.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP this edge.
- idex_en  out  1  ID/EX register enable.
- idex_bubble_n  out  1  0 = ID/EX captures a bubble (write/mem-enables forced 0).
- halt_done  out  1  HALT has reached WB; pipeline quiescent.

## Operation
- Scoreboard slots EX, MEM: {v, dest[2:0], ld}. On advance: MEM←EX, EX←{RegWrite&accept, wr_sel, MemtoReg}; bubble → v=0. Frozen (mem_stall) → hold.
- match(slot) = slot.v & ((rd1_used & rd1_sel==slot.dest) | (rd2_used & rd2_sel==slot.dest)); r0 is an ordinary register. Regfile bypasses WB→ID, so no WB slot.
- hazard = id_valid & (FORWARD ? match(EX)&EX.ld : match(EX)|match(MEM)).
- Priority, per cycle (combinational outputs):
  - mem_stall: pc_en=ifid_en=idex_en=0, idex_bubble_n=1, ifid_flush=0, state/counter/scoreboard hold.
  - branch_taken: pc_en=ifid_en=idex_en=1, ifid_flush=1, idex_bubble_n=0 (decode instruction squashed, incl. wrong-path HALT).
  - state≠RUN: pc_en=ifid_en=0, idex_en=1, idex_bubble_n=0.
  - hazard: pc_en=ifid_en=0, idex_en=1, idex_bubble_n=0.
  - else all enables 1, idex_bubble_n=1; accept=1.
- FSM: RUN → DRAIN when accept & id_valid & Halt (counter←2). DRAIN: counter decrements per non-frozen cycle; at 0 → HALTED. HALTED: halt_done=1, terminal until reset.
- accept = id_valid & not frozen & not branch_taken & RUN & !hazard.

## Timing
- Reset (rst_n=0, async): state RUN, counter 0, scoreboard v=0; outputs pc_en=ifid_en=idex_en=idex_bubble_n=1, ifid_flush=0, halt_done=0. Reset mid-drain or mid-stall returns to these immediately.
- All outputs combinational from current inputs + state; state updates on rising clk.
- Load-use, FORWARD=1: exactly 1 bubble cycle. FORWARD=0: dependent directly after writer stalls 2 cycles, one instruction gap → 1.
- Taken branch: 1 ID/EX bubble + 1 IF/ID flush in same cycle.
- mem_stall during a hazard stall extends it; hazard re-evaluated when released.
- HALT accepted at edge N → halt_done asserted from edge N+3 (mem_stall cycles add 1:1).

## Test plan
- FORWARD=1, LD r2 then ADD r3,r2,r1 → exactly 1 cycle pc_en=ifid_en=0, idex_bubble_n=0; ADD enters EX next cycle.
- FORWARD=0, ADDI r4 then SUB r5,r4,r4 → 2 bubble cycles; with one NOP between → 1; rd*_used=0 on r4 → 0.
- branch_taken=1 with HALT in decode → ifid_flush=1, idex_bubble_n=0, state stays RUN, halt_done never asserts.
- mem_stall=1 for 4 cycles during load-use stall → all enables 0, scoreboard held; after release 1 bubble, then advance.
- HALT accepted at cycle 10 → pc_en=0 from cycle 10 onward, halt_done=1 from cycle 13; with mem_stall at cycle 11 → 14.
- rst_n low during DRAIN → same cycle all enables 1, halt_done=0, scoreboard empty (no false hazard).
